// File: rtl/multiword_addsub_seq.sv
// multiword_addsub_seq: byte-serial multi-precision adder/subtractor.
// One shared 8-bit CLA is stepped over W bytes, least-significant byte first.
// The inter-byte carry is held in a register. Latency is W+1 cycles.
// Optional feature: define MWAS_SAT_EN to saturate the result on signed overflow.
// Without it, the result wraps and sat is tied 0.

// claAddSub8: 8-bit carry-lookahead adder/subtractor with group generate/propagate.
module claAddSub8 (
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic       cin,
   input  logic       sub,
   output logic [7:0] out,
   output logic       cout,
   output logic       v,
   output logic       g,
   output logic       p
);

   logic [7:0] yy;
   logic [7:0] gen_b;
   logic [7:0] prop_b;
   logic [8:0] c;

   // Operand conditioning and per-bit generate/propagate terms
   always_comb begin
      yy     = sub ? ~y : y;
      gen_b  = x & yy;
      prop_b = x ^ yy;
   end

   // Carry lookahead across the byte, plus group generate/propagate
   always_comb begin
      logic cc;
      logic gg;
      c  = '0;
      cc = cin;
      gg = 1'b0;
      for (int i = 0; i < 8; i++) begin
         c[i] = cc;
         cc   = gen_b[i] | (prop_b[i] & cc);
         gg   = gen_b[i] | (prop_b[i] & gg);
      end
      c[8] = cc;
      out  = prop_b ^ c[7:0];
      cout = c[8];
      v    = c[8] ^ c[7];
      g    = gg;
      p    = &prop_b;
   end

endmodule

// Top-level controller: operand latch, byte counter, carry register, and a three-process FSM.
module multiword_addsub_seq #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           sub,
   input  logic [W*8-1:0] a,
   input  logic [W*8-1:0] b,
   output logic           busy,
   output logic           done,
   output logic [W*8-1:0] result,
   output logic           cout,
   output logic           v,
   output logic           sat
);

   localparam int K_W = (W > 1) ? $clog2(W) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(W - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [K_W-1:0]   k;
   logic             carry_q;
   logic             sub_q;
   logic             cout_q;
   logic             v_q;
   logic [W-1:0][7:0] a_q;
   logic [W-1:0][7:0] b_q;
   logic [W-1:0][7:0] result_q;

   logic [7:0] cla_x;
   logic [7:0] cla_y;
   logic [7:0] cla_out;
   logic       cla_cout;
   logic       cla_v;
   logic       cla_g_unused;
   logic       cla_p_unused;
   logic       accept;
   logic       last_byte;

`ifdef MWAS_SAT_EN
   logic sat_q;

   // Signed limit toward which an overflowed result is clamped, chosen by A's sign.
   function automatic logic [W*8-1:0] sat_limit(input logic a_msb);
      logic signed [W*8-1:0] lim;
      lim = a_msb ? {1'b1, {(W*8-1){1'b0}}} : {1'b0, {(W*8-1){1'b1}}};
      return lim;
   endfunction
`endif

   assign accept    = (state == S_IDLE) && start;
   assign last_byte = (k == K_LAST);

   // Byte-select mux feeding the shared CLA; subtraction is a + ~b + 1
   always_comb begin
      cla_x = a_q[k];
      cla_y = sub_q ? ~b_q[k] : b_q[k];
   end

   claAddSub8 u_cla (
      .x    (cla_x),
      .y    (cla_y),
      .cin  (carry_q),
      .sub  (1'b0),
      .out  (cla_out),
      .cout (cla_cout),
      .v    (cla_v),
      .g    (cla_g_unused),
      .p    (cla_p_unused)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last_byte) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode from state only, so there is no path from start/a/b to outputs
   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // Operand latch on an accepted start; only read during RUN, so it needs no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q   <= a;
         b_q   <= b;
         sub_q <= sub;
      end
   end

   // Byte counter, carry chain, result bytes and final flags
   always_ff @(posedge clk) begin
      if (rst) begin
         k        <= '0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         v_q      <= 1'b0;
`ifdef MWAS_SAT_EN
         sat_q    <= 1'b0;
`endif
      end else if (accept) begin
         k       <= '0;
         carry_q <= sub;
`ifdef MWAS_SAT_EN
         sat_q   <= 1'b0;
`endif
      end else if (state == S_RUN) begin
         result_q[k] <= cla_out;
         carry_q     <= cla_cout;
         k           <= last_byte ? '0 : k + 1'b1;
         if (last_byte) begin
            cout_q <= cla_cout;
            v_q    <= cla_v;
`ifdef MWAS_SAT_EN
            if (cla_v) begin
               result_q <= sat_limit(a_q[W-1][7]);
               sat_q    <= 1'b1;
            end
`endif
         end
      end
   end

   assign result = result_q;
   assign cout   = cout_q;
   assign v      = v_q;
`ifdef MWAS_SAT_EN
   assign sat    = sat_q;
`else
   assign sat    = 1'b0;
`endif

endmodule
